// File: rtl/mult_accumulator_pkg.sv
// Shared types and width helpers for the multiply-accumulate stage.
package mult_pkg;

  typedef enum logic [0:0] {
    ACCUM = 1'b0,
    DONE  = 1'b1
  } state_e;

  // The accumulator gets clog2(M) guard bits above the 2*N product.
  // M*(2^N-1)^2 therefore cannot overflow.
  function automatic int acc_width(input int n, input int m);
    return 2 * n + $clog2(m);
  endfunction

  function automatic int cnt_width(input int m);
    return $clog2(m) + 1;
  endfunction

endpackage

// File: rtl/mult_accumulator.sv
// Sums up to M product terms into a wide accumulator.
// Presents each dot-product result on a registered valid/ready output.
module mult_accumulator
  import mult_pkg::*;
#(
  parameter  int N     = 4,
  parameter  int M     = 4,
  localparam int ACC_W = acc_width(N, M),
  localparam int CNT_W = cnt_width(M)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2*N-1:0]   p,
  input  logic             in_valid,
  input  logic             in_last,
  output logic             in_ready,
  input  logic             clr,
  output logic [ACC_W-1:0] out_sum,
  output logic [CNT_W-1:0] out_terms,
  output logic             out_valid,
  input  logic             out_ready
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high. in_ready is high only in ACCUM, out_valid only in DONE. So
  // input and output never overlap, and at most one result is in flight.

  state_e           state;
  logic [ACC_W-1:0] acc;
  logic [CNT_W-1:0] count;

  logic             fire;
  logic             final_term;
  logic [ACC_W-1:0] sum_next;

  assign in_ready   = (state == ACCUM);
  assign out_valid  = (state == DONE);
  assign fire       = in_valid & in_ready;
  assign final_term = in_last | (count == CNT_W'(M - 1));
  assign sum_next   = acc + ACC_W'(p);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ACCUM;
      acc       <= '0;
      count     <= '0;
      out_sum   <= '0;
      out_terms <= '0;
    end else if (clr) begin
      // Abort: discards a partial sum, a colliding term, or a pending result
      state <= ACCUM;
      acc   <= '0;
      count <= '0;
    end else begin
      case (state)
        ACCUM: begin
          if (fire) begin
            if (final_term) begin
              out_sum   <= sum_next;
              out_terms <= count + CNT_W'(1);
              acc       <= '0;
              count     <= '0;
              state     <= DONE;
            end else begin
              acc   <= sum_next;
              count <= count + CNT_W'(1);
            end
          end
        end
        DONE: begin
          if (out_ready) state <= ACCUM;
        end
        default: state <= ACCUM;
      endcase
    end
  end

endmodule
